// File: rtl/bcd_code_converter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_code_converter                                           |
// | Description : Sequential binary-to-decimal converter (shift-add-3, one bit |
// |               per clock) with selectable digit code on the output:         |
// |               8421, excess-3 or 2421 (Aiken).                              |
// | Ports       : clk, rst_n      - clock, asynchronous active-low reset        |
// |               in_valid/ready  - operand handshake (in_bin, in_mode)        |
// |               out_valid/ready - result handshake (out_code, out_ovf)       |
// |               out_code        - 4-bit digits, units in bits [3:0]          |
// |               out_ovf         - operand did not fit in DIGITS digits       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bcd_code_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_bin,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_code,
  output logic                  out_ovf
);

  localparam int C_BW = 4 * DIGITS;
  localparam int C_CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_ENCODE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_bin;
  logic [C_BW-1:0]   r_bcd;
  logic [1:0]        r_mode;
  logic              r_ovf;
  logic [C_CW-1:0]   r_cnt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [C_BW-1:0]   r_out_code;
  logic              r_out_ovf;

  logic [C_BW-1:0]   w_adj;
  logic [C_BW-1:0]   w_enc;
  logic [C_BW-1:0]   w_bcd_nxt;

  // Per-digit add-3 correction (for the shift) and output code mapping
  // (applied to the finished BCD value).
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [3:0] w_d;
    logic [3:0] w_e;

    assign w_d = r_bcd[4*g +: 4];
    assign w_adj[4*g +: 4] = (w_d >= 4'd5) ? (w_d + 4'd3) : w_d;

    always_comb begin
      w_e = w_d;
      case (r_mode)
        2'b01:   w_e = w_d + 4'd3;
        2'b10:   w_e = (w_d >= 4'd5) ? (w_d + 4'd6) : w_d;
        default: w_e = w_d;  // 00 and reserved 11 both give plain 8421
      endcase
    end

    assign w_enc[4*g +: 4] = w_e;
  end

  // The bit leaving the top digit is the 10^DIGITS carry; dropping it
  // leaves the operand modulo 10^DIGITS in the digits.
  assign w_bcd_nxt = {w_adj[C_BW-2:0], r_bin[WIDTH-1]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (in_valid)         w_next = S_SHIFT;
      S_SHIFT:  if (r_cnt == C_LAST)  w_next = S_ENCODE;
      S_ENCODE:                       w_next = S_DONE;
      S_DONE:   if (out_ready)        w_next = S_IDLE;
      default:                        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_mode      <= 2'b00;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_code  <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_state     <= w_next;
      // Handshake flags follow the state being entered, so they are
      // registered yet exactly aligned with IDLE / DONE.
      r_in_ready  <= (w_next == S_IDLE);
      r_out_valid <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_bin  <= in_bin;
            r_mode <= in_mode;
            r_bcd  <= '0;
            r_ovf  <= 1'b0;
            r_cnt  <= '0;
          end
        end
        S_SHIFT: begin
          r_bcd <= w_bcd_nxt;
          r_bin <= r_bin << 1;
          r_ovf <= r_ovf | w_adj[C_BW-1];
          r_cnt <= r_cnt + 1'b1;
        end
        S_ENCODE: begin
          r_out_code <= w_enc;
          r_out_ovf  <= r_ovf;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_code  = r_out_code;
  assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire
